// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel button debouncer with one shared sample tick.
// Ports: clk, rst (sync, active-high), i_btn[N_BTN] raw buttons,
//   o_level stable level, o_rise / o_fall one-clk edge pulses,
//   o_long one-clk long-press pulse.
// Build option: define BTN_LONG_PRESS_EN to build the per-channel hold
//   counters; otherwise o_long is tied to 0 and the port list is unchanged.
module btn_debounce_multi #(
  parameter int N_BTN       = 4,
  parameter int CLK_DIV     = 100,
  parameter int SHIFT_DEPTH = 4,
  parameter int LONG_TICKS  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_rise,
  output logic [N_BTN-1:0] o_fall,
  output logic [N_BTN-1:0] o_long
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0]          div_cnt;
  logic                   tick;

  logic [N_BTN-1:0]       sync_a;
  logic [N_BTN-1:0]       sync_b;

  logic [SHIFT_DEPTH-1:0] shreg [N_BTN];
  logic [N_BTN-1:0]       all_hi;
  logic [N_BTN-1:0]       all_lo;

  logic [N_BTN-1:0]       level;
  logic [N_BTN-1:0]       level_d;

  // Shared sample tick: one clk high every CLK_DIV clks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= i_btn;
      sync_b <= sync_a;
    end
  end

  // Sample history, newest sample in bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_BTN; k++) begin
        shreg[k] <= '0;
      end
    end else if (tick) begin
      for (int k = 0; k < N_BTN; k++) begin
        shreg[k] <= {shreg[k][SHIFT_DEPTH-2:0], sync_b[k]};
      end
    end
  end

  always_comb begin
    all_hi = '0;
    all_lo = '0;
    for (int k = 0; k < N_BTN; k++) begin
      all_hi[k] = &shreg[k];
      all_lo[k] = ~|shreg[k];
    end
  end

  // Hysteresis: a unanimous window sets or clears, mixed holds.
  // all_hi and all_lo can never both be set for one channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      level_d <= '0;
    end else begin
      level   <= (level | all_hi) & ~all_lo;
      level_d <= level;
    end
  end

  assign o_level = level;
  assign o_rise  = level & ~level_d;
  assign o_fall  = ~level & level_d;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TICKS - 1);

  logic [HW-1:0]    hold [N_BTN];
  logic [N_BTN-1:0] long_q;

  // Hold counter saturates at LONG_TICKS so the pulse fires once
  // per press; it restarts only after the level drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_q <= '0;
      for (int k = 0; k < N_BTN; k++) begin
        hold[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_BTN; k++) begin
        long_q[k] <= 1'b0;
        if (!level[k]) begin
          hold[k] <= '0;
        end else if (tick && hold[k] != HOLD_MAX) begin
          hold[k]   <= hold[k] + HW'(1);
          long_q[k] <= (hold[k] == HOLD_PRE);
        end
      end
    end
  end

  assign o_long = long_q;
`else
  assign o_long = '0;
`endif

endmodule
